fht_but_array: RTL and testbench

FHT_BUT_ARRAY -- requirements
Module: fht_but_array

---
 rtl/fht_pkg.sv | 32 +++
 rtl/fht_but_array_if.sv | 46 ++++
 rtl/fht_but_core.sv | 92 +++++++++
 rtl/fht_but_array.sv | 155 +++++++++++++++
 tb/tb_fht_but_array.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fht_pkg.sv
// ============================================================================
// Module      : fht_pkg
// Description : Shared types and constants for the FHT butterfly array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fht_pkg;

    localparam int c_d_bit_default   = 17;
    localparam int c_w_bit_default   = 12;
    localparam int c_sec_bit_default = 4;
    localparam int c_nbut_default    = 2;

    // Twiddle 1.0 sits at 2^(W_BIT-2); rounding bias is half an LSB of that.
    localparam int c_tw_frac_ofs = 2;
    localparam int c_round_ofs   = 3;

    typedef enum logic [1:0] {
        LANE_STRAIGHT = 2'd0,
        LANE_FIRST    = 2'd1,
        LANE_SECOND   = 2'd2
    } lane_ord_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_HAVE_A = 1'b1
    } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/fht_but_array_if.sv
// ============================================================================
// Module      : fht_but_array_if
// Description : Bank/twiddle input bus and result bus of the butterfly array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fht_but_array_if
    import fht_pkg::*;
#(
    parameter int D_BIT   = c_d_bit_default,
    parameter int W_BIT   = c_w_bit_default,
    parameter int SEC_BIT = c_sec_bit_default,
    parameter int NBUT    = c_nbut_default
);
    logic                      iVALID;
    logic                      iBEAT;
    logic                      iST_ZERO;
    logic                      iST_LAST;
    logic                      i2ND_PART_SUBSEC;
    logic                      iSCALE;
    logic [SEC_BIT-1:0]        iSECTOR;
    logic [2*NBUT*D_BIT-1:0]   iBANK;
    logic [NBUT*W_BIT-1:0]     iSIN;
    logic [NBUT*W_BIT-1:0]     iCOS;
    logic                      iCLR_ERR;
    logic                      oVALID;
    logic [2*NBUT*D_BIT-1:0]   oY;
    logic                      oOVF;
    logic                      oSEQ_ERR;

    modport master (
        output iVALID, iBEAT, iST_ZERO, iST_LAST, i2ND_PART_SUBSEC, iSCALE,
               iSECTOR, iBANK, iSIN, iCOS, iCLR_ERR,
        input  oVALID, oY, oOVF, oSEQ_ERR
    );

    modport slave (
        input  iVALID, iBEAT, iST_ZERO, iST_LAST, i2ND_PART_SUBSEC, iSCALE,
               iSECTOR, iBANK, iSIN, iCOS, iCLR_ERR,
        output oVALID, oY, oOVF, oSEQ_ERR
    );

endinterface

`default_nettype wire

// File: rtl/fht_but_core.sv
// ============================================================================
// Module      : fht_but_core
// Description : One radix-2 FHT butterfly, two register stages.
//               FHT_SAT_EN selects clamping (with overflow flag) over wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fht_but_core
    import fht_pkg::*;
#(
    parameter int D_BIT = c_d_bit_default,
    parameter int W_BIT = c_w_bit_default
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_zero,
    input  wire logic                    i_scale,
    input  wire logic signed [D_BIT-1:0] i_x0,
    input  wire logic signed [D_BIT-1:0] i_x1,
    input  wire logic signed [D_BIT-1:0] i_x2,
    input  wire logic signed [W_BIT-1:0] i_sin,
    input  wire logic signed [W_BIT-1:0] i_cos,
    output logic signed [D_BIT-1:0]      o_a,
    output logic signed [D_BIT-1:0]      o_b,
    output logic                         o_ovf
);
    localparam int c_mw = D_BIT + W_BIT;
    localparam int c_pw = c_mw + 1;
    localparam int c_aw = c_pw + 1;
    localparam logic signed [c_pw-1:0] c_round = {{(c_pw-1){1'b0}}, 1'b1} << (W_BIT - c_round_ofs);
    localparam logic signed [c_aw-1:0] c_one   = {{(c_aw-1){1'b0}}, 1'b1};
    localparam logic signed [c_aw-1:0] c_max   = {{(c_aw-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
    localparam logic signed [c_aw-1:0] c_min   = {{(c_aw-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};

    logic signed [c_mw-1:0] w_m1, w_m2;
    logic signed [c_pw-1:0] w_sum, w_p;
    logic signed [c_pw-1:0] r_p;
    logic signed [D_BIT-1:0] r_x0;
    logic                    r_scale;
    logic signed [c_aw-1:0] w_a, w_b, w_as, w_bs;

    assign w_m1  = c_mw'(i_x1) * c_mw'(i_cos);
    assign w_m2  = c_mw'(i_x2) * c_mw'(i_sin);
    assign w_sum = c_pw'(w_m1) + c_pw'(w_m2) + c_round;
    assign w_p   = i_zero ? c_pw'(i_x1) : (w_sum >>> (W_BIT - c_tw_frac_ofs));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_x0    <= '0;
            r_scale <= 1'b0;
        end else begin
            r_p     <= w_p;
            r_x0    <= i_x0;
            r_scale <= i_scale;
        end
    end

    // Sums are kept at full product width so scaling and clamping see exact values.
    assign w_a  = c_aw'(r_x0) + c_aw'(r_p);
    assign w_b  = c_aw'(r_x0) - c_aw'(r_p);
    assign w_as = r_scale ? ((w_a + c_one) >>> 1) : w_a;
    assign w_bs = r_scale ? ((w_b + c_one) >>> 1) : w_b;

    function automatic logic signed [D_BIT-1:0] f_clip(input logic signed [c_aw-1:0] v);
        logic signed [c_aw-1:0] c;
        c = (v > c_max) ? c_max : ((v < c_min) ? c_min : v);
        return c[D_BIT-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            o_a   <= '0;
            o_b   <= '0;
            o_ovf <= 1'b0;
        end else begin
`ifdef FHT_SAT_EN
            o_a   <= f_clip(w_as);
            o_b   <= f_clip(w_bs);
            o_ovf <= (w_as > c_max) || (w_as < c_min) || (w_bs > c_max) || (w_bs < c_min);
`else
            o_a   <= w_as[D_BIT-1:0];
            o_b   <= w_bs[D_BIT-1:0];
            o_ovf <= 1'b0;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/fht_but_array.sv
// ============================================================================
// Module      : fht_but_array
// Description : Two-beat bank assembly feeding NBUT butterflies, 3-cycle latency.
//               FHT_SAT_EN enables result clamping and the overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fht_but_array
    import fht_pkg::*;
#(
    parameter int D_BIT   = c_d_bit_default,
    parameter int W_BIT   = c_w_bit_default,
    parameter int SEC_BIT = c_sec_bit_default,
    parameter int NBUT    = c_nbut_default
) (
    input  wire logic       iCLK,
    input  wire logic       iRESET,
    fht_but_array_if.slave  bus
);
    fsm_state_t r_state, w_state_nxt;
    logic       w_cap_a, w_launch, w_seq_set;

    logic [NBUT*D_BIT-1:0]   r_x1_h, r_x2_h;
    logic [NBUT*D_BIT-1:0]   r_x0_s, r_x1_s, r_x2_s;
    logic [NBUT*W_BIT-1:0]   r_sin_s, r_cos_s;
    logic                    r_zero_s, r_scale_s;
    lane_ord_t               w_ord, r_ord_1, r_ord_2, r_ord_3;
    logic                    r_v1, r_v2, r_v3;
    logic [NBUT*D_BIT-1:0]   w_a, w_b;
    logic [NBUT-1:0]         w_ovf;
    logic [2*NBUT*D_BIT-1:0] w_y, r_y;
    logic                    r_valid, r_ovf, r_seq_err;

    always_ff @(posedge iCLK) begin
        if (iRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_a     = 1'b0;
        w_launch    = 1'b0;
        w_seq_set   = 1'b0;
        if (bus.iVALID && !bus.iBEAT) begin
            w_cap_a     = 1'b1;
            w_state_nxt = ST_HAVE_A;
        end else if (bus.iVALID && bus.iBEAT) begin
            if (r_state == ST_HAVE_A) begin
                w_launch    = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_seq_set   = 1'b1;
            end
        end
    end

    always_comb begin
        w_ord = LANE_FIRST;
        if (bus.iST_LAST)              w_ord = LANE_STRAIGHT;
        else if (bus.i2ND_PART_SUBSEC) w_ord = LANE_SECOND;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_x1_h <= '0; r_x2_h <= '0;
            r_x0_s <= '0; r_x1_s <= '0; r_x2_s <= '0;
            r_sin_s <= '0; r_cos_s <= '0;
            r_zero_s <= 1'b0; r_scale_s <= 1'b0;
            r_ord_1 <= LANE_STRAIGHT; r_ord_2 <= LANE_STRAIGHT; r_ord_3 <= LANE_STRAIGHT;
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
        end else begin
            for (int k = 0; k < NBUT; k++) begin
                if (w_cap_a) begin
                    r_x1_h[k*D_BIT +: D_BIT] <= bus.iBANK[(2*k)*D_BIT +: D_BIT];
                    r_x2_h[k*D_BIT +: D_BIT] <= bus.iBANK[(2*k+1)*D_BIT +: D_BIT];
                end
                if (w_launch) r_x0_s[k*D_BIT +: D_BIT] <= bus.iBANK[(2*k)*D_BIT +: D_BIT];
            end
            if (w_launch) begin
                r_x1_s    <= r_x1_h;
                r_x2_s    <= r_x2_h;
                r_sin_s   <= bus.iSIN;
                r_cos_s   <= bus.iCOS;
                r_zero_s  <= bus.iST_ZERO || (bus.iSECTOR == '0);
                r_scale_s <= bus.iSCALE;
                r_ord_1   <= w_ord;
            end
            r_v1    <= w_launch;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_ord_2 <= r_ord_1;
            r_ord_3 <= r_ord_2;
        end
    end

    for (genvar k = 0; k < NBUT; k++) begin : g_but
        fht_but_core #(.D_BIT(D_BIT), .W_BIT(W_BIT)) u_core (
            .clk     (iCLK),
            .rst     (iRESET),
            .i_zero  (r_zero_s),
            .i_scale (r_scale_s),
            .i_x0    (r_x0_s[k*D_BIT +: D_BIT]),
            .i_x1    (r_x1_s[k*D_BIT +: D_BIT]),
            .i_x2    (r_x2_s[k*D_BIT +: D_BIT]),
            .i_sin   (r_sin_s[k*W_BIT +: W_BIT]),
            .i_cos   (r_cos_s[k*W_BIT +: W_BIT]),
            .o_a     (w_a[k*D_BIT +: D_BIT]),
            .o_b     (w_b[k*D_BIT +: D_BIT]),
            .o_ovf   (w_ovf[k])
        );
    end

    // Butterflies pair up (k, k+1); concatenations list lanes high to low.
    always_comb begin
        w_y = '0;
        for (int g = 0; g < NBUT/2; g++) begin
            case (r_ord_3)
                LANE_FIRST:  w_y[4*g*D_BIT +: 4*D_BIT] =
                    {w_b[(2*g+1)*D_BIT +: D_BIT], w_b[2*g*D_BIT +: D_BIT],
                     w_a[(2*g+1)*D_BIT +: D_BIT], w_a[2*g*D_BIT +: D_BIT]};
                LANE_SECOND: w_y[4*g*D_BIT +: 4*D_BIT] =
                    {w_b[2*g*D_BIT +: D_BIT], w_b[(2*g+1)*D_BIT +: D_BIT],
                     w_a[2*g*D_BIT +: D_BIT], w_a[(2*g+1)*D_BIT +: D_BIT]};
                default:     w_y[4*g*D_BIT +: 4*D_BIT] =
                    {w_b[(2*g+1)*D_BIT +: D_BIT], w_a[(2*g+1)*D_BIT +: D_BIT],
                     w_b[2*g*D_BIT +: D_BIT], w_a[2*g*D_BIT +: D_BIT]};
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_valid   <= 1'b0;
            r_y       <= '0;
            r_ovf     <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_valid <= r_v3;
            if (r_v3) r_y <= w_y;
            if (r_v3 && (|w_ovf)) r_ovf <= 1'b1;
            else if (bus.iCLR_ERR) r_ovf <= 1'b0;
            if (w_seq_set)         r_seq_err <= 1'b1;
            else if (bus.iCLR_ERR) r_seq_err <= 1'b0;
        end
    end

    assign bus.oVALID   = r_valid;
    assign bus.oY       = r_y;
    assign bus.oOVF     = r_ovf;
    assign bus.oSEQ_ERR = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_fht_but_array.sv
// ============================================================================
// Module      : tb_fht_but_array
// Description : Directed self-checking bench for fht_but_array (NBUT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fht_but_array;
    localparam int D  = 17;
    localparam int W  = 12;
    localparam int S  = 4;
    localparam int NB = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fht_but_array_if #(.D_BIT(D), .W_BIT(W), .SEC_BIT(S), .NBUT(NB)) bus ();

    fht_but_array #(.D_BIT(D), .W_BIT(W), .SEC_BIT(S), .NBUT(NB)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*NB*D-1:0] mk_bank(input int l0, l1, l2, l3);
        logic [2*NB*D-1:0] b;
        b = {D'(l3), D'(l2), D'(l1), D'(l0)};
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(input logic zero, last, part2, scale, input int sec,
                            input int cos0, sin0, cos1, sin1);
        bus.iST_ZERO         = zero;
        bus.iST_LAST         = last;
        bus.i2ND_PART_SUBSEC = part2;
        bus.iSCALE           = scale;
        bus.iSECTOR          = S'(sec);
        bus.iCOS             = {W'(cos1), W'(cos0)};
        bus.iSIN             = {W'(sin1), W'(sin0)};
    endtask

    task automatic beat(input logic b, input logic [2*NB*D-1:0] bank);
        bus.iVALID = 1'b1;
        bus.iBEAT  = b;
        bus.iBANK  = bank;
        tick(1);
        bus.iVALID = 1'b0;
        bus.iBANK  = '0;
    endtask

    task automatic test_reset;
        beat(1'b0, mk_bank(1, 2, 3, 4));
        beat(1'b1, mk_bank(5, 6, 7, 8));
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.oVALID !== 1'b0) begin
                n_err++; $display("FAIL reset_flush cyc%0d oVALID got %b want 0", i, bus.oVALID);
            end
            tick(1);
        end
        n_cmp++;
        if (bus.oY !== '0) begin n_err++; $display("FAIL reset_oY got %h want 0", bus.oY); end
        n_cmp++;
        if (bus.oOVF !== 1'b0) begin n_err++; $display("FAIL reset_oOVF got %b want 0", bus.oOVF); end
        n_cmp++;
        if (bus.oSEQ_ERR !== 1'b0) begin n_err++; $display("FAIL reset_oSEQ_ERR got %b want 0", bus.oSEQ_ERR); end
    endtask

    task automatic test_straight;
        set_mode(1'b0, 1'b1, 1'b0, 1'b0, 1, 1024, 0, 1024, 0);
        beat(1'b0, mk_bank(50, 0, 0, 0));
        beat(1'b1, mk_bank(100, 0, 0, 0));
        tick(2);
        n_cmp++;
        if (bus.oVALID !== 1'b0) begin n_err++; $display("FAIL straight_early oVALID got %b want 0", bus.oVALID); end
        tick(1);
        n_cmp++;
        if (bus.oVALID !== 1'b1) begin n_err++; $display("FAIL straight_valid got %b want 1", bus.oVALID); end
        n_cmp++;
        if (bus.oY !== mk_bank(150, 50, 0, 0)) begin
            n_err++; $display("FAIL straight_oY got %h want %h", bus.oY, mk_bank(150, 50, 0, 0));
        end
        tick(1);
        n_cmp++;
        if (bus.oVALID !== 1'b0) begin n_err++; $display("FAIL straight_pulse oVALID got %b want 0", bus.oVALID); end
        n_cmp++;
        if (bus.oY !== mk_bank(150, 50, 0, 0)) begin
            n_err++; $display("FAIL straight_hold got %h want %h", bus.oY, mk_bank(150, 50, 0, 0));
        end
    endtask

    task automatic test_scale;
        set_mode(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1024, 0, 1024);
        beat(1'b0, mk_bank(7, -20, 0, 0));
        beat(1'b1, mk_bank(5, 0, 0, 0));
        tick(3);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(-7, 13, 0, 0)) begin
            n_err++; $display("FAIL scale_oY v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(-7, 13, 0, 0));
        end
    endtask

    task automatic test_pair;
        set_mode(1'b1, 1'b0, 1'b0, 1'b0, 3, 77, 55, 77, 55);
        beat(1'b0, mk_bank(3, 999, 5, 999));
        beat(1'b1, mk_bank(10, 888, 20, 888));
        tick(3);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(13, 25, 7, 15)) begin
            n_err++; $display("FAIL pair_first v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(13, 25, 7, 15));
        end
        set_mode(1'b1, 1'b0, 1'b1, 1'b0, 3, 77, 55, 77, 55);
        beat(1'b0, mk_bank(3, 999, 5, 999));
        beat(1'b1, mk_bank(10, 888, 20, 888));
        tick(3);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(25, 13, 15, 7)) begin
            n_err++; $display("FAIL pair_second v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(25, 13, 15, 7));
        end
    endtask

    task automatic test_overflow;
        logic [2*NB*D-1:0] exp_y;
        logic              exp_ovf;
`ifdef FHT_SAT_EN
        exp_y   = mk_bank(65535, 0, 0, 0);
        exp_ovf = 1'b1;
`else
        exp_y   = mk_bank(-2, 0, 0, 0);
        exp_ovf = 1'b0;
`endif
        set_mode(1'b0, 1'b1, 1'b0, 1'b0, 0, 100, 200, 100, 200);
        beat(1'b0, mk_bank(65535, 12345, 0, 0));
        beat(1'b1, mk_bank(65535, 0, 0, 0));
        tick(3);
        n_cmp++;
        if (bus.oY !== exp_y) begin n_err++; $display("FAIL ovf_oY got %h want %h", bus.oY, exp_y); end
        n_cmp++;
        if (bus.oOVF !== exp_ovf) begin n_err++; $display("FAIL ovf_flag got %b want %b", bus.oOVF, exp_ovf); end
        bus.iCLR_ERR = 1'b1;
        tick(1);
        bus.iCLR_ERR = 1'b0;
        n_cmp++;
        if (bus.oOVF !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", bus.oOVF); end
    endtask

    task automatic test_seq_err;
        set_mode(1'b0, 1'b1, 1'b0, 1'b0, 1, 1024, 0, 1024, 0);
        beat(1'b1, mk_bank(1, 1, 1, 1));
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.oVALID !== 1'b0) begin n_err++; $display("FAIL seq_drop cyc%0d oVALID got %b want 0", i, bus.oVALID); end
            tick(1);
        end
        n_cmp++;
        if (bus.oSEQ_ERR !== 1'b1) begin n_err++; $display("FAIL seq_set got %b want 1", bus.oSEQ_ERR); end
        bus.iCLR_ERR = 1'b1;
        tick(1);
        bus.iCLR_ERR = 1'b0;
        n_cmp++;
        if (bus.oSEQ_ERR !== 1'b0) begin n_err++; $display("FAIL seq_clear got %b want 0", bus.oSEQ_ERR); end
        bus.iCLR_ERR = 1'b1;
        beat(1'b1, mk_bank(1, 1, 1, 1));
        bus.iCLR_ERR = 1'b0;
        n_cmp++;
        if (bus.oSEQ_ERR !== 1'b1) begin n_err++; $display("FAIL seq_set_wins got %b want 1", bus.oSEQ_ERR); end
        bus.iCLR_ERR = 1'b1;
        tick(1);
        bus.iCLR_ERR = 1'b0;
        beat(1'b0, mk_bank(4, 4, 4, 4));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        beat(1'b1, mk_bank(2, 2, 2, 2));
        n_cmp++;
        if (bus.oSEQ_ERR !== 1'b1) begin n_err++; $display("FAIL seq_after_reset got %b want 1", bus.oSEQ_ERR); end
        tick(3);
        n_cmp++;
        if (bus.oVALID !== 1'b0) begin n_err++; $display("FAIL seq_after_reset_valid got %b want 0", bus.oVALID); end
        bus.iCLR_ERR = 1'b1;
        tick(1);
        bus.iCLR_ERR = 1'b0;
    endtask

    task automatic test_overwrite;
        set_mode(1'b0, 1'b1, 1'b0, 1'b0, 1, 1024, 0, 1024, 0);
        beat(1'b0, mk_bank(99, 0, 0, 0));
        beat(1'b0, mk_bank(5, 0, 0, 0));
        beat(1'b1, mk_bank(1, 0, 0, 0));
        n_cmp++;
        if (bus.oSEQ_ERR !== 1'b0) begin n_err++; $display("FAIL overwrite_no_err got %b want 0", bus.oSEQ_ERR); end
        tick(3);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(6, -4, 0, 0)) begin
            n_err++; $display("FAIL overwrite_oY v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(6, -4, 0, 0));
        end
    endtask

    task automatic test_back_to_back;
        set_mode(1'b0, 1'b1, 1'b0, 1'b0, 1, 1024, 0, 1024, 0);
        beat(1'b0, mk_bank(10, 0, 2, 100));
        beat(1'b1, mk_bank(1, 0, 0, 0));
        beat(1'b0, mk_bank(3, 0, 0, 0));
        beat(1'b1, mk_bank(4, 0, 0, 0));
        tick(1);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(11, -9, 2, -2)) begin
            n_err++; $display("FAIL b2b_first v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(11, -9, 2, -2));
        end
        tick(1);
        n_cmp++;
        if (bus.oVALID !== 1'b0) begin n_err++; $display("FAIL b2b_gap got %b want 0", bus.oVALID); end
        tick(1);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(7, 1, 0, 0)) begin
            n_err++; $display("FAIL b2b_second v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(7, 1, 0, 0));
        end
    endtask

    task automatic test_reset_release_a;
        set_mode(1'b0, 1'b1, 1'b0, 1'b0, 1, 1024, 0, 1024, 0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        beat(1'b0, mk_bank(8, 0, 0, 0));
        beat(1'b1, mk_bank(2, 0, 0, 0));
        tick(3);
        n_cmp++;
        if (bus.oVALID !== 1'b1 || bus.oY !== mk_bank(10, -6, 0, 0)) begin
            n_err++; $display("FAIL release_a v=%b got %h want %h", bus.oVALID, bus.oY, mk_bank(10, -6, 0, 0));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.iVALID = 1'b0;
        bus.iBEAT  = 1'b0;
        bus.iBANK  = '0;
        bus.iCLR_ERR = 1'b0;
        set_mode(1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0);
        tick(3);
        rst = 1'b0;
        test_reset;
        test_straight;
        test_scale;
        test_pair;
        test_overflow;
        test_seq_err;
        test_overwrite;
        test_back_to_back;
        test_reset_release_a;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
